// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clk_gen reference-clock generator.
// Optional build macro used by the generator files: CLK_GEN_DUTY50_EN.
package clk_gen_pkg;

  localparam int unsigned DIV_MIN       = 2;
  localparam int unsigned DIV_WIDTH_DEF = 16;

  typedef logic [DIV_WIDTH_DEF-1:0] div_t;

  // Rounded period ratio, clamped to what a width-bit divider can represent.
  function automatic int unsigned calc_div(input int unsigned period,
                                           input int unsigned src_period,
                                           input int unsigned width);
    longint unsigned d;
    longint unsigned dmax;
    d    = (64'(period) + 64'(src_period / 2)) / 64'(src_period);
    dmax = (64'd1 << width) - 64'd1;
    if (d < 64'(DIV_MIN)) begin
      d = 64'(DIV_MIN);
    end else if (d > dmax) begin
      d = dmax;
    end
    return 32'(d);
  endfunction

endpackage

// File: rtl/clk_gen_cnt.sv
// Period counter for clk_gen: wraps at div-1 and flags whether the next count is in the high phase.
// With CLK_GEN_DUTY50_EN the high phase is floor(div/2); the top adds the extra half cycle.
module clk_gen_cnt
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 wrap_o,
  output logic                 high_next_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] high_len;

  // >= rather than == keeps the counter bounded even if div_i were ever to shrink mid-period.
  assign wrap_o = (cnt_q >= (div_i - 1'b1));

`ifdef CLK_GEN_DUTY50_EN
  assign high_len = div_i >> 1;
`else
  assign high_len = div_i - (div_i >> 1);
`endif

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || wrap_o) begin
      cnt_d = '0;
    end
  end

  assign high_next_o = (cnt_d < high_len);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_gen.sv
// Integer-divided, glitch-free reference clock with a runtime valid/ready divider update.
// CLK_GEN_DUTY50_EN adds a falling-edge flop so odd divisors give an exact 50% duty cycle.
module clk_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned CLK_PERIOD = 30517,
  parameter int unsigned SRC_PERIOD = 10,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 div_valid_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 div_ready_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 clk_o,
  output logic                 tick_o
);

  localparam int unsigned          DEFAULT_DIV = calc_div(CLK_PERIOD, SRC_PERIOD, DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_RST     = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_LO      = DIV_WIDTH'(DIV_MIN);

  logic                 run_q, run_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 pend_q, pend_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
  logic                 wrap;
  logic                 high_next;
  logic                 clr;

  // Idle holds the counter at 0; a stop request only lands on the wrap so no runt pulse escapes.
  assign clr = ~run_q | (wrap & ~en_i);

  clk_gen_cnt #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr),
    .div_i      (div_q),
    .wrap_o     (wrap),
    .high_next_o(high_next)
  );

  always_comb begin
    run_d  = run_q ? ~(wrap & ~en_i) : en_i;
    clk_d  = run_d & high_next;
    tick_d = clk_d & ~clk_q;
    div_d  = div_q;
    pend_d = pend_q;
    pdiv_d = pdiv_q;
    // Apply and accept are mutually exclusive: acceptance needs pend_q low.
    if (pend_q && (!run_q || wrap)) begin
      div_d  = pdiv_q;
      pend_d = 1'b0;
    end else if (div_valid_i && !pend_q) begin
      pend_d = 1'b1;
      pdiv_d = (div_i < DIV_LO) ? DIV_LO : div_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      pend_q <= 1'b0;
      div_q  <= DIV_RST;
      pdiv_q <= DIV_RST;
    end else begin
      run_q  <= run_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      pend_q <= pend_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
    end
  end

`ifdef CLK_GEN_DUTY50_EN
  logic neg_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_q & div_q[0];
    end
  end

  assign clk_o = clk_q | neg_q;
`else
  assign clk_o = clk_q;
`endif

  assign tick_o      = tick_q;
  assign div_o       = div_q;
  assign div_ready_o = ~pend_q;

endmodule

// File: tb/tb_clk_gen.sv
// Scoreboard bench for clk_gen: stimulus queues per-cycle expectations, a monitor pops and compares.
module tb_clk_gen;

  typedef struct packed {
    logic [15:0] id;
    logic        c;
    logic        t;
    logic [15:0] d;
    logic        r;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        vld;
  logic [15:0] din;
  logic        rdy;
  logic [15:0] div_w;
  logic        clk_w;
  logic        tick_w;

  logic        en_def;
  logic        rdy_def;
  logic [15:0] div_def;
  logic        clk_def;
  logic        tick_def;

  exp_t        exp_q[$];
  int          n_chk;
  int          n_pass;
  int          step_id;

  clk_gen #(
    .CLK_PERIOD(40),
    .SRC_PERIOD(10),
    .DIV_WIDTH (16)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .div_valid_i(vld),
    .div_i      (din),
    .div_ready_o(rdy),
    .div_o      (div_w),
    .clk_o      (clk_w),
    .tick_o     (tick_w)
  );

  clk_gen u_def (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en_def),
    .div_valid_i(1'b0),
    .div_i      (16'd0),
    .div_ready_o(rdy_def),
    .div_o      (div_def),
    .clk_o      (clk_def),
    .tick_o     (tick_def)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, req);
  endtask

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic e, input logic v, input logic [15:0] d,
                      input logic ec, input logic et, input logic [15:0] ed, input logic er);
    exp_t x;
    en  = e;
    vld = v;
    din = d;
    x.id = 16'(step_id);
    x.c  = ec;
    x.t  = et;
    x.d  = ed;
    x.r  = er;
    exp_q.push_back(x);
    step_id++;
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if ({clk_w, tick_w, div_w, rdy} === {e.c, e.t, e.d, e.r}) n_pass++;
        else $display("FAIL step%0d: got clk=%b tick=%b div=%0d rdy=%b expected clk=%b tick=%b div=%0d rdy=%b",
                      e.id, clk_w, tick_w, div_w, rdy, e.c, e.t, e.d, e.r);
      end
    end
  end

  initial begin
    int  hi;
    int  lo;
    bit  found;
    n_chk   = 0;
    n_pass  = 0;
    step_id = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    vld     = 1'b0;
    din     = 16'd0;
    en_def  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_clk", 32'(clk_w), 0);
    chk("rst_tick", 32'(tick_w), 0);
    chk("rst_div", 32'(div_w), 4);
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_def_div", 32'(div_def), 3052);
    chk("rst_def_clk", 32'(clk_def), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle, then start with default divider 4: 1,1,0,0 repeating.
    step(0, 0, 0, 0, 0, 4, 1);
    step(1, 0, 0, 1, 1, 4, 1);
    step(1, 0, 0, 1, 0, 4, 1);
    step(1, 0, 0, 0, 0, 4, 1);
    step(1, 0, 0, 0, 0, 4, 1);
    step(1, 0, 0, 1, 1, 4, 1);
    step(1, 0, 0, 1, 0, 4, 1);
    step(1, 0, 0, 0, 0, 4, 1);
    step(1, 0, 0, 0, 0, 4, 1);

    // Mid-period request for 5; a second request while busy is ignored.
    step(1, 0, 0, 1, 1, 4, 1);
    step(1, 1, 5, 1, 0, 4, 0);
    step(1, 1, 7, 0, 0, 4, 0);
    step(1, 0, 0, 0, 0, 4, 0);
    step(1, 0, 0, 1, 1, 5, 1);
    step(1, 0, 0, 1, 0, 5, 1);
    step(1, 0, 0, 1, 0, 5, 1);
    step(1, 0, 0, 0, 0, 5, 1);
    step(1, 0, 0, 0, 0, 5, 1);
    step(1, 0, 0, 1, 1, 5, 1);

    // Request 0 clamps to 2: toggle every cycle after the wrap.
    step(1, 1, 0, 1, 0, 5, 0);
    step(1, 0, 0, 1, 0, 5, 0);
    step(1, 0, 0, 0, 0, 5, 0);
    step(1, 0, 0, 0, 0, 5, 0);
    step(1, 0, 0, 1, 1, 2, 1);
    step(1, 0, 0, 0, 0, 2, 1);
    step(1, 0, 0, 1, 1, 2, 1);
    step(1, 0, 0, 0, 0, 2, 1);
    step(1, 0, 0, 1, 1, 2, 1);

    // Back to 4, then drop enable at cnt=1: period finishes and output stays low.
    step(1, 1, 4, 0, 0, 2, 0);
    step(1, 0, 0, 1, 1, 4, 1);
    step(1, 0, 0, 1, 0, 4, 1);
    step(0, 0, 0, 0, 0, 4, 1);
    step(0, 0, 0, 0, 0, 4, 1);
    step(0, 0, 0, 0, 0, 4, 1);
    step(0, 0, 0, 0, 0, 4, 1);
    step(0, 0, 0, 0, 0, 4, 1);

    // Request while stopped applies without a wrap.
    step(0, 1, 3, 0, 0, 4, 0);
    step(0, 0, 0, 0, 0, 3, 1);

    // Re-enable: tick on the next edge, odd divider 3 gives 1,1,0.
    step(1, 0, 0, 1, 1, 3, 1);
    step(1, 0, 0, 1, 0, 3, 1);
    step(1, 0, 0, 0, 0, 3, 1);
    step(1, 0, 0, 1, 1, 3, 1);

    // Enable low mid-period but high again at the wrap: no stop.
    step(0, 0, 0, 1, 0, 3, 1);
    step(0, 0, 0, 0, 0, 3, 1);
    step(1, 0, 0, 1, 1, 3, 1);
    step(1, 0, 0, 1, 0, 3, 1);

    // Asynchronous reset while the output is high.
    chk("pre_rst_clk", 32'(clk_w), 1);
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("async_rst_clk", 32'(clk_w), 0);
    chk("async_rst_tick", 32'(tick_w), 0);
    chk("async_rst_div", 32'(div_w), 4);
    chk("async_rst_rdy", 32'(rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 0, 0, 1, 1, 4, 1);
    step(1, 0, 0, 1, 0, 4, 1);
    step(1, 0, 0, 0, 0, 4, 1);

    // Default parameters: divider 3052, 1526 high and 1526 low.
    en_def = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk);
      #1;
      if (tick_def === 1'b1) found = 1'b1;
    end
    chk("def_start_tick", 32'(found), 1);
    hi = 0;
    while (clk_def === 1'b1 && hi < 4000) begin
      hi++;
      @(posedge clk);
      #1;
      if (tick_def !== 1'b0) hi = 9999;
    end
    lo = 0;
    while (clk_def === 1'b0 && lo < 4000) begin
      lo++;
      @(posedge clk);
      #1;
    end
    chk("def_high_len", 32'(hi), 1526);
    chk("def_low_len", 32'(lo), 1526);
    chk("def_tick_again", 32'(tick_def), 1);
    chk("def_div", 32'(div_def), 3052);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
